// File: rtl/serial_tx_fifo_pkg.sv
// Shared types and configuration helpers for the buffered UART transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  // Baud divisor rounded to the nearest whole clock count.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic bit cfg_ok(input int unsigned data_w, input int unsigned fifo_depth,
                                input int unsigned stop_bits);
    return (data_w >= 5) && (data_w <= 9) && (fifo_depth >= 2) &&
           ((fifo_depth & (fifo_depth - 1)) == 0) && (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/serial_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered flags; the head word is visible on dout without a read.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, rptr_q, wptr_d, rptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr, do_rd;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign do_wr  = wr && !full;
  assign do_rd  = rd && !empty;
  assign wptr_d = wptr_q + PW'(do_wr);
  assign rptr_d = rptr_q + PW'(do_rd);
  assign dout   = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      level  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      full   <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      empty  <= (wptr_d == rptr_d);
      level  <= wptr_d - rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/serial_tx_fifo.sv
// Buffered UART transmitter: write FIFO, internal baud generator and configurable frame format.
module serial_tx_fifo import serial_pkg::*; #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [DATA_W-1:0]                 i_data,
  input  logic                              i_data_w,
  input  logic                              i_ovf_clr,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
  output logic                              o_busy,
  output logic                              o_overflow,
  output logic                              o_uart_tx
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned BW  = $clog2(DATA_W);
  localparam parity_t     PMODE = parity_t'(PARITY[1:0]);

  if (!cfg_ok(DATA_W, FIFO_DEPTH, STOP_BITS) || (PARITY > 2) || (DIV < 2)) begin : g_bad_cfg
    $error("serial_tx_fifo: illegal parameter combination");
  end

  tx_state_t          state_q, state_d;
  logic [CW-1:0]      baud_q, baud_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               busy_q, ovf_q;
  logic               pop, tick, head_par;
  logic [DATA_W-1:0]  fifo_dout;
  logic               fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .wr    (i_data_w),
    .din   (i_data),
    .rd    (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

  assign tick       = (baud_q == CW'(DIV - 1));
  assign head_par   = (^fifo_dout) ^ (PMODE == ODD);
  assign o_full     = fifo_full;
  assign o_empty    = fifo_empty;
  assign o_busy     = busy_q;
  assign o_overflow = ovf_q;
  assign o_uart_tx  = tx_q;

  // Next-state, shift register and next line level; tx is registered from tx_d.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          par_d   = head_par;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: if (tick) begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = DATA;
        tx_d    = shreg_q[0];
      end
      DATA: if (tick) begin
        baud_d = '0;
        if (bit_q == BW'(DATA_W - 1)) begin
          bit_d = '0;
          if (PMODE != NONE) begin
            state_d = PAR;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d   = bit_q + BW'(1);
          shreg_d = shreg_q >> 1;
          tx_d    = shreg_q[1];
        end
      end
      PAR: if (tick) begin
        baud_d  = '0;
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (tick) begin
        baud_d = '0;
        if (bit_q == BW'(STOP_BITS - 1)) begin
          bit_d = '0;
          // Chain directly into the next frame when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            par_d   = head_par;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Sticky overflow; a dropped write outranks a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                 ovf_q <= 1'b0;
    else if (i_data_w && fifo_full) ovf_q <= 1'b1;
    else if (i_ovf_clr)             ovf_q <= 1'b0;
  end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo: default-format DUT plus small-divisor parity and 7N2 variants.
module tb_serial_tx_fifo;

  localparam int DIV   = 434;
  localparam int SDIV  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_passed = 0;

  // Main DUT, default parameters
  logic [7:0] data = '0;
  logic       wr = 1'b0, clr = 1'b0;
  logic       full, empty, busy, ovf, tx;
  logic [4:0] level;

  serial_tx_fifo dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_data_w(wr), .i_ovf_clr(clr),
    .o_full(full), .o_empty(empty), .o_level(level), .o_busy(busy),
    .o_overflow(ovf), .o_uart_tx(tx)
  );

  // Even and odd parity variants with a 16-cycle bit
  logic [7:0] p_data = '0;
  logic       p_wr = 1'b0;
  logic       e_full, e_empty, e_busy, e_ovf, e_tx;
  logic       o_full, o_empty, o_busy, o_ovf, o_tx;
  logic [4:0] e_level, o_level;

  serial_tx_fifo #(.CLK_HZ(16), .BAUD(1), .PARITY(2)) dut_even (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(p_data), .i_data_w(p_wr), .i_ovf_clr(1'b0),
    .o_full(e_full), .o_empty(e_empty), .o_level(e_level), .o_busy(e_busy),
    .o_overflow(e_ovf), .o_uart_tx(e_tx)
  );

  serial_tx_fifo #(.CLK_HZ(16), .BAUD(1), .PARITY(1)) dut_odd (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(p_data), .i_data_w(p_wr), .i_ovf_clr(1'b0),
    .o_full(o_full), .o_empty(o_empty), .o_level(o_level), .o_busy(o_busy),
    .o_overflow(o_ovf), .o_uart_tx(o_tx)
  );

  // 7 data bits, two stop bits
  logic [6:0] w_data = '0;
  logic       w_wr = 1'b0;
  logic       w_full, w_empty, w_busy, w_ovf, w_tx;
  logic [4:0] w_level;

  serial_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_W(7), .STOP_BITS(2)) dut_w7 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(w_data), .i_data_w(w_wr), .i_ovf_clr(1'b0),
    .o_full(w_full), .o_empty(w_empty), .o_level(w_level), .o_busy(w_busy),
    .o_overflow(w_ovf), .o_uart_tx(w_tx)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    checks_total++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else checks_passed++;
    checks_total++;
    if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else checks_passed++;
    checks_total++;
    if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else checks_passed++;
    checks_total++;
    if (level !== 5'd0) $display("FAIL reset_level: got %0d want 0", level); else checks_passed++;
    checks_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else checks_passed++;
    checks_total++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else checks_passed++;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single_byte;
    logic [9:0] exp;
    exp = {1'b1, 8'h55, 1'b0};
    data = 8'h55;
    wr = 1'b1;
    step(1);
    wr = 1'b0;
    checks_total++;
    if (empty !== 1'b0 || level !== 5'd1 || tx !== 1'b1)
      $display("FAIL single_accept: empty=%b level=%0d tx=%b want 0 1 1", empty, level, tx);
    else checks_passed++;
    step(1);
    checks_total++;
    if (tx !== 1'b0 || busy !== 1'b1 || empty !== 1'b1 || level !== 5'd0)
      $display("FAIL single_pop: tx=%b busy=%b empty=%b level=%0d want 0 1 1 0", tx, busy, empty, level);
    else checks_passed++;
    for (int k = 0; k < 10; k++) begin
      checks_total++;
      if (tx !== exp[k]) $display("FAIL single_bit%0d_first: got %b want %b", k, tx, exp[k]);
      else checks_passed++;
      step(DIV - 1);
      checks_total++;
      if (tx !== exp[k] || busy !== 1'b1)
        $display("FAIL single_bit%0d_last: tx=%b busy=%b want %b 1", k, tx, busy, exp[k]);
      else checks_passed++;
      step(1);
    end
    checks_total++;
    if (busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL single_end: busy=%b tx=%b want 0 1", busy, tx);
    else checks_passed++;
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp;
    int gaps;
    exp = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    gaps = 0;
    data = 8'h00;
    wr = 1'b1;
    step(1);
    data = 8'hFF;
    step(1);
    wr = 1'b0;
    checks_total++;
    if (level !== 5'd1 || tx !== 1'b0)
      $display("FAIL b2b_wr_and_pop: level=%0d tx=%b want 1 0", level, tx);
    else checks_passed++;
    for (int k = 0; k < 20; k++) begin
      checks_total++;
      if (tx !== exp[k]) $display("FAIL b2b_bit%0d_first: got %b want %b", k, tx, exp[k]);
      else checks_passed++;
      repeat (DIV - 1) begin
        step(1);
        if (busy !== 1'b1) gaps++;
      end
      checks_total++;
      if (tx !== exp[k]) $display("FAIL b2b_bit%0d_last: got %b want %b", k, tx, exp[k]);
      else checks_passed++;
      step(1);
      if (k < 19 && busy !== 1'b1) gaps++;
    end
    checks_total++;
    if (gaps !== 0) $display("FAIL b2b_busy_gaps: got %0d want 0", gaps); else checks_passed++;
    checks_total++;
    if (busy !== 1'b0 || tx !== 1'b1 || empty !== 1'b1)
      $display("FAIL b2b_end: busy=%b tx=%b empty=%b want 0 1 1", busy, tx, empty);
    else checks_passed++;
  endtask

  task automatic test_overflow;
    wr = 1'b1;
    for (int i = 0; i < 18; i++) begin
      data = 8'(i + 1);
      step(1);
      if (i == 1) begin
        checks_total++;
        if (level !== 5'd1 || busy !== 1'b1)
          $display("FAIL ovf_first_pop: level=%0d busy=%b want 1 1", level, busy);
        else checks_passed++;
      end
      if (i == 15) begin
        checks_total++;
        if (level !== 5'd15 || full !== 1'b0)
          $display("FAIL ovf_pre_full: level=%0d full=%b want 15 0", level, full);
        else checks_passed++;
      end
      if (i == 16) begin
        checks_total++;
        if (level !== 5'd16 || full !== 1'b1 || ovf !== 1'b0)
          $display("FAIL ovf_full: level=%0d full=%b ovf=%b want 16 1 0", level, full, ovf);
        else checks_passed++;
      end
    end
    wr = 1'b0;
    checks_total++;
    if (level !== 5'd16 || ovf !== 1'b1)
      $display("FAIL ovf_dropped: level=%0d ovf=%b want 16 1", level, ovf);
    else checks_passed++;
    step(1);
    checks_total++;
    if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else checks_passed++;
    wr = 1'b1;
    clr = 1'b1;
    step(1);
    checks_total++;
    if (ovf !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", ovf); else checks_passed++;
    wr = 1'b0;
    step(1);
    clr = 1'b0;
    checks_total++;
    if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf); else checks_passed++;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (level !== 5'd0 || full !== 1'b0 || tx !== 1'b1)
      $display("FAIL ovf_flush: level=%0d full=%b tx=%b want 0 0 1", level, full, tx);
    else checks_passed++;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    bad = 0;
    data = 8'h00;
    wr = 1'b1;
    step(5);
    wr = 1'b0;
    checks_total++;
    if (level !== 5'd4 || busy !== 1'b1)
      $display("FAIL midrst_queued: level=%0d busy=%b want 4 1", level, busy);
    else checks_passed++;
    // Start bit began 3 edges ago; move to the middle of data bit 3.
    step(4 * DIV + 200 - 3);
    checks_total++;
    if (tx !== 1'b0) $display("FAIL midrst_in_bit3: got %b want 0", tx); else checks_passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (tx !== 1'b1 || level !== 5'd0 || empty !== 1'b1 || busy !== 1'b0)
      $display("FAIL midrst_async: tx=%b level=%0d empty=%b busy=%b want 1 0 1 0", tx, level, empty, busy);
    else checks_passed++;
    step(3);
    rst_n = 1'b1;
    repeat (3000) begin
      step(1);
      if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
    end
    checks_total++;
    if (bad !== 0) $display("FAIL midrst_after_release: got %0d bad cycles want 0", bad);
    else checks_passed++;
  endtask

  task automatic test_parity;
    logic [10:0] exp_e, exp_o;
    exp_e = {1'b1, 1'b1, 8'h07, 1'b0};
    exp_o = {1'b1, 1'b0, 8'h07, 1'b0};
    p_data = 8'h07;
    p_wr = 1'b1;
    step(1);
    p_wr = 1'b0;
    step(1);
    for (int k = 0; k < 11; k++) begin
      checks_total++;
      if (e_tx !== exp_e[k] || o_tx !== exp_o[k])
        $display("FAIL par_bit%0d_first: even=%b odd=%b want %b %b", k, e_tx, o_tx, exp_e[k], exp_o[k]);
      else checks_passed++;
      step(SDIV - 1);
      checks_total++;
      if (e_tx !== exp_e[k] || o_tx !== exp_o[k] || e_busy !== 1'b1 || o_busy !== 1'b1)
        $display("FAIL par_bit%0d_last: even=%b odd=%b busy=%b%b want %b %b 11",
                 k, e_tx, o_tx, e_busy, o_busy, exp_e[k], exp_o[k]);
      else checks_passed++;
      step(1);
    end
    checks_total++;
    if (e_busy !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL par_end_busy: even=%b odd=%b want 0 0", e_busy, o_busy);
    else checks_passed++;
  endtask

  task automatic test_width7_stop2;
    logic [9:0] exp;
    exp = {2'b11, 7'h41, 1'b0};
    w_data = 7'h41;
    w_wr = 1'b1;
    step(1);
    w_wr = 1'b0;
    step(1);
    for (int k = 0; k < 10; k++) begin
      checks_total++;
      if (w_tx !== exp[k]) $display("FAIL w7_bit%0d_first: got %b want %b", k, w_tx, exp[k]);
      else checks_passed++;
      step(SDIV - 1);
      checks_total++;
      if (w_tx !== exp[k] || w_busy !== 1'b1)
        $display("FAIL w7_bit%0d_last: tx=%b busy=%b want %b 1", k, w_tx, w_busy, exp[k]);
      else checks_passed++;
      step(1);
    end
    checks_total++;
    if (w_busy !== 1'b0 || w_tx !== 1'b1)
      $display("FAIL w7_end: busy=%b tx=%b want 0 1", w_busy, w_tx);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_parity();
    test_width7_stop2();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
